// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO block: APB register byte offsets, the
// register-select enum produced by the address decoder, and limits.
// No ports (package).
package gpio_pkg;

  // Widest function-select field the block is meant to be built with.
  localparam int W_FSEL_MAX = 4;

  localparam logic [15:0] OFF_OUT       = 16'h0000;
  localparam logic [15:0] OFF_OUT_SET   = 16'h0004;
  localparam logic [15:0] OFF_OUT_CLR   = 16'h0008;
  localparam logic [15:0] OFF_OUT_XOR   = 16'h000C;
  localparam logic [15:0] OFF_OE        = 16'h0010;
  localparam logic [15:0] OFF_IN        = 16'h0014;
  localparam logic [15:0] OFF_RISE_EN   = 16'h0020;
  localparam logic [15:0] OFF_FALL_EN   = 16'h0024;
  localparam logic [15:0] OFF_STATUS    = 16'h0028;
  localparam logic [15:0] OFF_FSEL_BASE = 16'h0040;

  typedef enum logic [3:0] {
    REG_NONE,
    REG_OUT,
    REG_OUT_SET,
    REG_OUT_CLR,
    REG_OUT_XOR,
    REG_OE,
    REG_IN,
    REG_RISE_EN,
    REG_FALL_EN,
    REG_STATUS,
    REG_FSEL
  } reg_sel_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-pad two-flop input synchroniser followed by a "previous value" flop,
// giving a clean synchronised level plus single-cycle rise/fall strobes.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   async_i      raw pad inputs (asynchronous to clk)
//   sync_o       synchronised level (second sync stage)
//   rise_o       1 for one cycle after sync_o goes 0->1
//   fall_o       1 for one cycle after sync_o goes 1->0
module gpio_sync_edge #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] async_i,
  output logic [N-1:0] sync_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o
);

  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;
  logic [N-1:0] prev_q;

  // NOTE: non-blocking assignments make every stage sample the value of the
  // previous stage from before the edge; blocking here would collapse the
  // chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // prev_q resets low, so a pad that is low out of reset never reports an edge.
  assign sync_o = sync2_q;
  assign rise_o = sync2_q & ~prev_q;
  assign fall_o = ~sync2_q & prev_q;

endmodule

// File: rtl/gpio_mux_irq.sv
// APB-attached GPIO block with per-pad function select, atomic output
// aliases, synchronised inputs and W1C rise/fall edge interrupts.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   apbs_*                     APB slave (pready tied 1, pslverr on unmapped)
//   pad_out, pad_oe            to pad ring (value, drive enable)
//   pad_in                     from pad ring, asynchronous
//   periph_out, periph_oe      peripheral drives; pad p function f>=1 at
//                              bit p*(N_FUNCS-1)+f-1
//   periph_in                  synchronised pad level to all peripherals
//   irq                        level interrupt, OR of STATUS, from a flop
module gpio_mux_irq
  import gpio_pkg::*;
#(
  parameter int N_PADS = 16,
  parameter int W_FSEL = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  apbs_psel,
  input  logic                                  apbs_penable,
  input  logic                                  apbs_pwrite,
  input  logic [15:0]                           apbs_paddr,
  input  logic [31:0]                           apbs_pwdata,
  output logic [31:0]                           apbs_prdata,
  output logic                                  apbs_pready,
  output logic                                  apbs_pslverr,
  output logic [N_PADS-1:0]                     pad_out,
  output logic [N_PADS-1:0]                     pad_oe,
  input  logic [N_PADS-1:0]                     pad_in,
  input  logic [N_PADS*((1<<W_FSEL)-1)-1:0]     periph_out,
  input  logic [N_PADS*((1<<W_FSEL)-1)-1:0]     periph_oe,
  output logic [N_PADS-1:0]                     periph_in,
  output logic                                  irq
);

  localparam int N_FUNCS     = 1 << W_FSEL;
  localparam int PPR         = 32 / W_FSEL;                 // pads per FSEL word
  localparam int N_FSEL_REGS = (N_PADS + PPR - 1) / PPR;

  // ---------------------------------------------------------------- decode
  logic [15:0] addr_w;
  logic [13:0] fsel_idx;
  reg_sel_e    sel;
  logic        wr_en;
  logic        unused_paddr;

  assign addr_w       = {apbs_paddr[15:2], 2'b00};
  assign fsel_idx     = apbs_paddr[15:2] - OFF_FSEL_BASE[15:2];
  assign wr_en        = apbs_psel & apbs_penable & apbs_pwrite;
  assign unused_paddr = ^apbs_paddr[1:0];

  always_comb begin
    sel = REG_NONE;
    case (addr_w)
      OFF_OUT:     sel = REG_OUT;
      OFF_OUT_SET: sel = REG_OUT_SET;
      OFF_OUT_CLR: sel = REG_OUT_CLR;
      OFF_OUT_XOR: sel = REG_OUT_XOR;
      OFF_OE:      sel = REG_OE;
      OFF_IN:      sel = REG_IN;
      OFF_RISE_EN: sel = REG_RISE_EN;
      OFF_FALL_EN: sel = REG_FALL_EN;
      OFF_STATUS:  sel = REG_STATUS;
      default: begin
        if (addr_w >= OFF_FSEL_BASE &&
            addr_w <  OFF_FSEL_BASE + 16'(4 * N_FSEL_REGS))
          sel = REG_FSEL;
      end
    endcase
  end

  // ------------------------------------------------------------- input path
  logic [N_PADS-1:0] sync_lvl;
  logic [N_PADS-1:0] rise;
  logic [N_PADS-1:0] fall;

  gpio_sync_edge #(.N(N_PADS)) u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (pad_in),
    .sync_o  (sync_lvl),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  assign periph_in = sync_lvl;

  // -------------------------------------------------------------- registers
  logic [N_PADS-1:0] out_q,     out_d;
  logic [N_PADS-1:0] oe_q,      oe_d;
  logic [N_PADS-1:0] rise_en_q, rise_en_d;
  logic [N_PADS-1:0] fall_en_q, fall_en_d;
  logic [N_PADS-1:0] status_q,  status_d;
  logic [W_FSEL-1:0] fsel_q [N_PADS];
  logic [W_FSEL-1:0] fsel_d [N_PADS];
  logic              irq_q;
  logic [N_PADS-1:0] wdata_p;
  logic [N_PADS-1:0] edge_set;

  assign wdata_p  = apbs_pwdata[N_PADS-1:0];
  assign edge_set = (rise & rise_en_q) | (fall & fall_en_q);

  // NOTE: every output of this block is given its hold value first, so no
  // path through the case leaves a variable unassigned and no latch appears.
  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    fsel_d    = fsel_q;
    // New edges are OR-ed in after the W1C mask, so set beats clear.
    status_d  = status_q | edge_set;
    if (wr_en) begin
      case (sel)
        REG_OUT:     out_d     = wdata_p;
        REG_OUT_SET: out_d     = out_q | wdata_p;
        REG_OUT_CLR: out_d     = out_q & ~wdata_p;
        REG_OUT_XOR: out_d     = out_q ^ wdata_p;
        REG_OE:      oe_d      = wdata_p;
        REG_RISE_EN: rise_en_d = wdata_p;
        REG_FALL_EN: fall_en_d = wdata_p;
        REG_STATUS:  status_d  = (status_q & ~wdata_p) | edge_set;
        REG_FSEL: begin
          for (int p = 0; p < N_PADS; p++) begin
            if (fsel_idx == 14'(p / PPR))
              fsel_d[p] = apbs_pwdata[(p % PPR) * W_FSEL +: W_FSEL];
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the FSEL array is a register file, not a RAM, and it must come out
  // of reset selecting bitbash, so each entry is explicitly reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
      for (int p = 0; p < N_PADS; p++) fsel_q[p] <= '0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      // Registered from the next STATUS value so irq tracks STATUS with no
      // extra cycle and no combinational glitching.
      irq_q     <= |status_d;
      fsel_q    <= fsel_d;
    end
  end

  assign irq = irq_q;

  // -------------------------------------------------------------- read mux
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (sel)
      REG_OUT:     rdata[N_PADS-1:0] = out_q;
      REG_OE:      rdata[N_PADS-1:0] = oe_q;
      REG_IN:      rdata[N_PADS-1:0] = sync_lvl;
      REG_RISE_EN: rdata[N_PADS-1:0] = rise_en_q;
      REG_FALL_EN: rdata[N_PADS-1:0] = fall_en_q;
      REG_STATUS:  rdata[N_PADS-1:0] = status_q;
      REG_FSEL: begin
        for (int p = 0; p < N_PADS; p++) begin
          if (fsel_idx == 14'(p / PPR))
            rdata[(p % PPR) * W_FSEL +: W_FSEL] = fsel_q[p];
        end
      end
      default: ;  // write-only aliases and unmapped addresses read 0
    endcase
  end

  assign apbs_prdata  = apbs_psel ? rdata : 32'h0;
  assign apbs_pready  = 1'b1;
  assign apbs_pslverr = apbs_psel & (sel == REG_NONE);

  // ------------------------------------------------------------ output mux
  // Each pad gets a choice vector {functions N-1..1, bitbash}; the select
  // field is exactly wide enough to index it, so every code is decoded.
  logic [N_FUNCS-1:0] out_choices;
  logic [N_FUNCS-1:0] oe_choices;

  always_comb begin
    pad_out     = '0;
    pad_oe      = '0;
    out_choices = '0;
    oe_choices  = '0;
    for (int p = 0; p < N_PADS; p++) begin
      out_choices = {periph_out[p*(N_FUNCS-1) +: N_FUNCS-1], out_q[p]};
      oe_choices  = {periph_oe [p*(N_FUNCS-1) +: N_FUNCS-1], oe_q[p]};
      pad_out[p]  = out_choices[fsel_q[p]];
      pad_oe[p]   = oe_choices[fsel_q[p]];
    end
  end

endmodule

// File: tb/tb_gpio_mux_irq.sv
module tb_gpio_mux_irq;

  localparam int N_PADS = 16;
  localparam int W_FSEL = 2;
  localparam int NF1    = 3;   // peripheral functions per pad

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [15:0] pad_out, pad_oe, periph_in;
  logic [15:0] pad_in = '0;
  logic [47:0] periph_out = '0, periph_oe = '0;
  logic        irq;

  always #5 clk = ~clk;

  gpio_mux_irq #(.N_PADS(N_PADS), .W_FSEL(W_FSEL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .apbs_psel    (psel),
    .apbs_penable (penable),
    .apbs_pwrite  (pwrite),
    .apbs_paddr   (paddr),
    .apbs_pwdata  (pwdata),
    .apbs_prdata  (prdata),
    .apbs_pready  (pready),
    .apbs_pslverr (pslverr),
    .pad_out      (pad_out),
    .pad_oe       (pad_oe),
    .pad_in       (pad_in),
    .periph_out   (periph_out),
    .periph_oe    (periph_oe),
    .periph_in    (periph_in),
    .irq          (irq)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Register contents as the programmer sees them, plus the pad level as it
  // was sampled 1, 2 and 3 clock edges ago (IN is the value from 2 edges ago).
  logic [15:0] m_out = '0, m_oe = '0, m_rise_en = '0, m_fall_en = '0, m_status = '0;
  int          m_fsel [N_PADS];
  logic [15:0] seen1 = '0, seen2 = '0, seen3 = '0;
  logic [15:0] m_ev, m_w, m_st;

  initial for (int p = 0; p < N_PADS; p++) m_fsel[p] = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = '0; m_oe = '0; m_rise_en = '0; m_fall_en = '0; m_status = '0;
      seen1 = '0; seen2 = '0; seen3 = '0;
      for (int p = 0; p < N_PADS; p++) m_fsel[p] = 0;
    end else begin
      // An edge is the IN value differing from the one before it, gated by
      // the enables in force before this clock.
      m_ev = ((seen2 & ~seen3) & m_rise_en) | ((~seen2 & seen3) & m_fall_en);
      m_st = m_status;
      if (psel && penable && pwrite) begin
        m_w = pwdata[15:0];
        case ({paddr[15:2], 2'b00})
          16'h0000: m_out = m_w;
          16'h0004: m_out = m_out | m_w;
          16'h0008: m_out = m_out & ~m_w;
          16'h000C: m_out = m_out ^ m_w;
          16'h0010: m_oe = m_w;
          16'h0020: m_rise_en = m_w;
          16'h0024: m_fall_en = m_w;
          16'h0028: m_st = m_st & ~m_w;
          16'h0040: for (int p = 0; p < N_PADS; p++) m_fsel[p] = int'((pwdata >> (2 * p)) & 32'h3);
          default: ;
        endcase
      end
      m_status = m_st | m_ev;
      seen3 = seen2;
      seen2 = seen1;
      seen1 = pad_in;
    end
  end

  function automatic logic model_mapped(input logic [15:0] a);
    case ({a[15:2], 2'b00})
      16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014,
      16'h0020, 16'h0024, 16'h0028, 16'h0040: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_read();
    logic [31:0] r;
    r = '0;
    if (psel) begin
      case ({paddr[15:2], 2'b00})
        16'h0000: r = {16'h0, m_out};
        16'h0010: r = {16'h0, m_oe};
        16'h0014: r = {16'h0, seen2};
        16'h0020: r = {16'h0, m_rise_en};
        16'h0024: r = {16'h0, m_fall_en};
        16'h0028: r = {16'h0, m_status};
        16'h0040: for (int p = 0; p < N_PADS; p++) r = r | (32'(m_fsel[p]) << (2 * p));
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Compare process: all outputs against the model, mid-cycle.
  logic [15:0] e_out, e_oe;
  always @(negedge clk) begin
    if (chk_en) begin
      e_out = '0;
      e_oe  = '0;
      for (int p = 0; p < N_PADS; p++) begin
        if (m_fsel[p] == 0) begin
          e_out[p] = m_out[p];
          e_oe[p]  = m_oe[p];
        end else begin
          e_out[p] = periph_out[p * NF1 + m_fsel[p] - 1];
          e_oe[p]  = periph_oe[p * NF1 + m_fsel[p] - 1];
        end
      end
      check("pad_out", pad_out, e_out);
      check("pad_oe", pad_oe, e_oe);
      check("periph_in", periph_in, seen2);
      check("irq", irq, m_status != 16'h0);
      check("prdata", prdata, model_read());
      check("pslverr", pslverr, psel && !model_mapped(paddr));
      check("pready", pready, 1'b1);
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic e);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    tick();
    penable = 1'b1;
    @(negedge clk);
    d = prdata;
    e = pslverr;
    @(posedge clk);
    #2;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    // 1. reset
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    tick();
    check("reset pad_oe", pad_oe, 16'h0);
    check("reset irq", irq, 1'b0);
    check("reset prdata idle", prdata, 32'h0);
    rst_n = 1'b1;
    tick();
    apb_read(16'h0000, rd, er); check("reset OUT", rd, 32'h0);
    apb_read(16'h0010, rd, er); check("reset OE", rd, 32'h0);
    apb_read(16'h0028, rd, er); check("reset STATUS", rd, 32'h0);
    apb_read(16'h0100, rd, er); check("unmapped pslverr", er, 1'b1);
    apb_write(16'h0100, 32'hFFFF_FFFF);   // no effect anywhere

    // 2. atomic aliases
    apb_write(16'h0000, 32'h0000_00F0);
    apb_write(16'h0010, 32'h0000_FFFF);
    apb_write(16'h0004, 32'h0000_0001);
    apb_write(16'h0008, 32'h0000_0010);
    apb_write(16'h000C, 32'h0000_8000);
    apb_read(16'h0000, rd, er); check("OUT after aliases", rd, 32'h0000_80E1);
    check("pad_out after aliases", pad_out, 16'h80E1);
    apb_read(16'h0004, rd, er); check("OUT_SET reads 0", rd, 32'h0);

    // 3. pad1 -> function 2 (periph bit 1*3+1 = 4)
    apb_write(16'h0040, 32'h0000_0008);
    apb_read(16'h0040, rd, er); check("FSEL0 readback", rd, 32'h0000_0008);
    periph_oe[4] = 1'b1;
    periph_out[4] = 1'b1;
    #1 check("pad_out[1] periph high", pad_out[1], 1'b1);
    check("pad_oe[1] periph", pad_oe[1], 1'b1);
    periph_out[4] = 1'b0;
    #1 check("pad_out[1] periph low", pad_out[1], 1'b0);
    tick();
    apb_write(16'h000C, 32'h0000_0002);   // OUT bit1 -> 1, pad must ignore it
    check("pad_out ignores OUT bit1", pad_out, 16'h80E1);

    // 4. rise edge interrupt on pad2
    apb_write(16'h0020, 32'h0000_0004);
    pad_in[2] = 1'b1;
    @(posedge clk); #1;
    check("IN[2] after 1 edge", periph_in[2], 1'b0);
    @(posedge clk); #1;
    check("IN[2] after 2 edges", periph_in[2], 1'b1);
    check("irq after 2 edges", irq, 1'b0);
    @(posedge clk); #1;
    check("irq after 3 edges", irq, 1'b1);
    #1;
    apb_read(16'h0028, rd, er); check("STATUS after rise", rd, 32'h0000_0004);
    apb_read(16'h0014, rd, er); check("IN after rise", rd, 32'h0000_0004);
    apb_write(16'h0028, 32'h0000_0004);
    check("irq after W1C", irq, 1'b0);

    // 5. enable while high: no status; edge coinciding with W1C: set wins
    apb_write(16'h0020, 32'h0000_000C);
    apb_write(16'h0024, 32'h0000_0008);
    pad_in[3] = 1'b1;
    repeat (4) tick();
    apb_read(16'h0028, rd, er); check("STATUS pad3 rise only", rd, 32'h0000_0008);
    pad_in[3] = 1'b0;
    tick();
    apb_write(16'h0028, 32'h0000_0008);   // commits on the fall-edge clock
    check("irq after set-vs-W1C", irq, 1'b1);
    apb_write(16'h0024, 32'h0000_0000);   // dropping an enable keeps STATUS
    apb_read(16'h0028, rd, er); check("STATUS set wins", rd, 32'h0000_0008);
    apb_write(16'h0028, 32'h0000_0008);
    check("irq after plain W1C", irq, 1'b0);

    // 6. async reset during a transfer with STATUS all ones
    pad_in = 16'h0000;
    repeat (4) tick();
    apb_write(16'h0020, 32'h0000_FFFF);
    pad_in = 16'hFFFF;
    repeat (4) tick();
    apb_read(16'h0028, rd, er); check("STATUS all ones", rd, 32'h0000_FFFF);
    check("pad_oe before reset", pad_oe, 16'hFFFF);
    psel = 1'b1; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'h0000_1234;
    tick();
    penable = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("irq async drop", irq, 1'b0);
    check("pad_oe async drop", pad_oe, 16'h0);
    check("pad_out async drop", pad_out, 16'h0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    apb_read(16'h0028, rd, er); check("STATUS after reset", rd, 32'h0);
    apb_read(16'h0000, rd, er); check("OUT after reset", rd, 32'h0);
    apb_read(16'h0040, rd, er); check("FSEL0 after reset", rd, 32'h0);
    repeat (4) tick();
    check("no irq after reset with pads high", irq, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
